// File: rtl/controlador_varredura_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package pkg_display;

  // Scan FSM: APAGADO = dead-time with every anode off, ACESO = current digit lit
  typedef enum logic {
    APAGADO = 1'b0,
    ACESO   = 1'b1
  } estado_t;

  localparam int unsigned LARG_BCD            = 4;
  localparam int unsigned N_DIGITOS_PADRAO    = 4;
  localparam int unsigned DIV_REFRESH_PADRAO  = 50000;
  localparam int unsigned BLANK_CICLOS_PADRAO = 500;

endpackage : pkg_display

// File: rtl/controlador_varredura_display_supressor_zeros.sv
// Leading-zero blank mask: bit k set means digit k must stay dark.
module supressor_zeros
  import pkg_display::*;
#(
  parameter int unsigned N_DIGITOS = N_DIGITOS_PADRAO
) (
  input  logic [N_DIGITOS-1:0][LARG_BCD-1:0] ativo_i,
  input  logic                               supr_zeros_i,
  output logic [N_DIGITOS-1:0]               mascara_o_c
);

  logic todos_zero;

  // Walk from the most significant digit down; digit 0 is never blanked
  always_comb begin
    mascara_o_c = '0;
    todos_zero  = 1'b1;
    for (int k = N_DIGITOS - 1; k >= 1; k--) begin
      todos_zero     = todos_zero & (ativo_i[k] == '0);
      mascara_o_c[k] = supr_zeros_i & todos_zero;
    end
  end

endmodule : supressor_zeros

// File: rtl/controlador_varredura_display.sv
// Time-multiplexed scan controller for N common-anode digits sharing one BCD decoder.
module controlador_varredura_display
  import pkg_display::*;
#(
  parameter int unsigned N_DIGITOS    = N_DIGITOS_PADRAO,
  parameter int unsigned DIV_REFRESH  = DIV_REFRESH_PADRAO,
  parameter int unsigned BLANK_CICLOS = BLANK_CICLOS_PADRAO
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            carga_valid,
  output logic                            carga_ready,
  input  logic [LARG_BCD*N_DIGITOS-1:0]   dados_bcd,
  input  logic                            supr_zeros,
  output logic [LARG_BCD-1:0]             bcd_decod,
  output logic [N_DIGITOS-1:0]            anodo_n,
  output logic                            fim_quadro
);

  localparam int unsigned CNT_W = $clog2(DIV_REFRESH);
  localparam int unsigned IDX_W = $clog2(N_DIGITOS);

  typedef logic [N_DIGITOS-1:0][LARG_BCD-1:0] valor_t;

  estado_t              estado_q, estado_d;
  logic [N_DIGITOS-1:0] anodo_q, anodo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  valor_t               sombra_q, sombra_d;
  valor_t               ativo_q, ativo_d;
  logic                 pendente_q, pendente_d;
  logic                 pronto_q, pronto_d;
  logic [LARG_BCD-1:0]  bcd_q, bcd_d;
  logic                 fim_q, fim_d;
  logic                 fim_slot;
  logic                 aceita;
  logic [N_DIGITOS-1:0] mascara;

  // Blank mask is derived from the active value only, so it is constant within a frame
  supressor_zeros #(
    .N_DIGITOS (N_DIGITOS)
  ) u_supressor (
    .ativo_i      (ativo_q),
    .supr_zeros_i (supr_zeros),
    .mascara_o_c  (mascara)
  );

  // Slot counter, digit index and the early-decoded end-of-frame pulse
  always_comb begin
    fim_slot = (cnt_q == CNT_W'(DIV_REFRESH - 1));
    cnt_d    = fim_slot ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (fim_slot) begin
      idx_d = (idx_q == IDX_W'(N_DIGITOS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    fim_d = (cnt_q == CNT_W'(DIV_REFRESH - 2)) && (idx_q == IDX_W'(N_DIGITOS - 1));
  end

  // Load handshake: shadow captures, active swaps only on the frame-end edge
  always_comb begin
    aceita     = carga_valid & pronto_q;
    sombra_d   = sombra_q;
    ativo_d    = ativo_q;
    pendente_d = pendente_q;
    if (fim_q && pendente_q) begin
      ativo_d    = sombra_q;
      pendente_d = 1'b0;
    end
    if (aceita) begin
      sombra_d   = valor_t'(dados_bcd);
      pendente_d = 1'b1;
    end
    pronto_d = ~pendente_d;
    bcd_d    = ativo_d[idx_d];
  end

  // Scan FSM next state and anode pattern; pattern is latched at slot start
  always_comb begin
    estado_d = estado_q;
    anodo_d  = anodo_q;
    unique case (estado_q)
      APAGADO: begin
        if (cnt_q == CNT_W'(BLANK_CICLOS - 1)) begin
          estado_d       = ACESO;
          anodo_d        = '1;
          anodo_d[idx_q] = mascara[idx_q];
        end
      end
      ACESO: begin
        if (fim_slot) begin
          estado_d = APAGADO;
          anodo_d  = '1;
        end
      end
    endcase
  end

  // FSM state register and registered anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= APAGADO;
      anodo_q  <= '1;
    end else begin
      estado_q <= estado_d;
      anodo_q  <= anodo_d;
    end
  end

  // Counters, value registers and remaining registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sombra_q   <= '0;
      ativo_q    <= '0;
      pendente_q <= 1'b0;
      pronto_q   <= 1'b1;
      bcd_q      <= '0;
      fim_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sombra_q   <= sombra_d;
      ativo_q    <= ativo_d;
      pendente_q <= pendente_d;
      pronto_q   <= pronto_d;
      bcd_q      <= bcd_d;
      fim_q      <= fim_d;
    end
  end

  assign carga_ready = pronto_q;
  assign bcd_decod   = bcd_q;
  assign anodo_n     = anodo_q;
  assign fim_quadro  = fim_q;

endmodule : controlador_varredura_display

// File: tb/tb_controlador_varredura_display.sv
// Scoreboard bench for the display scan controller (N=4, DIV=8, BLANK=2).
module tb_controlador_varredura_display;

  localparam int unsigned N      = 4;
  localparam int unsigned DIV    = 8;
  localparam int unsigned BLANK  = 2;
  localparam int unsigned QUADRO = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        carga_valid;
  logic        carga_ready;
  logic [15:0] dados_bcd;
  logic        supr_zeros;
  logic [3:0]  bcd_decod;
  logic [3:0]  anodo_n;
  logic        fim_quadro;

  always #5 clk = ~clk;

  controlador_varredura_display #(
    .N_DIGITOS    (N),
    .DIV_REFRESH  (DIV),
    .BLANK_CICLOS (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .carga_valid (carga_valid),
    .carga_ready (carga_ready),
    .dados_bcd   (dados_bcd),
    .supr_zeros  (supr_zeros),
    .bcd_decod   (bcd_decod),
    .anodo_n     (anodo_n),
    .fim_quadro  (fim_quadro)
  );

  // Accepted load waiting to become the displayed value at cycle 'efetivo'
  typedef struct {
    logic [15:0] valor;
    int unsigned efetivo;
  } carga_t;

  carga_t      fila[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned k;
  logic [15:0] ativo_m;
  logic        aceso_m;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nvec++;
    if (obs !== esp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, esp, k);
    end
  endtask

  // One clock of stimulus: check outputs for cycle k, drive inputs, advance
  task automatic passo(input logic v, input logic [15:0] d, input logic s);
    int unsigned pos;
    int unsigned slot;
    int unsigned efetivo;
    logic [3:0]  an_esp;
    logic [15:0] desl;
    logic        pronto_esp;
    carga_t      c;
    pos  = k % DIV;
    slot = (k / DIV) % N;
    if (fila.size() > 0 && fila[0].efetivo == k) begin
      c       = fila.pop_front();
      ativo_m = c.valor;
    end
    pronto_esp = (fila.size() == 0);
    an_esp     = 4'hF;
    if (pos >= BLANK && aceso_m) an_esp[2'(slot)] = 1'b0;
    desl = ativo_m >> (4 * slot);
    verifica("anodo_n", 32'(anodo_n), 32'(an_esp));
    verifica("bcd_decod", 32'(bcd_decod), 32'(desl[3:0]));
    verifica("fim_quadro", 32'(fim_quadro), 32'(pos == DIV - 1 && slot == N - 1));
    verifica("carga_ready", 32'(carga_ready), 32'(pronto_esp));
    carga_valid = v;
    dados_bcd   = d;
    supr_zeros  = s;
    if (v && pronto_esp) begin
      efetivo = (k / QUADRO + 1) * QUADRO;
      if (k % QUADRO == QUADRO - 1) efetivo += QUADRO;
      fila.push_back('{d, efetivo});
    end
    if (pos == BLANK - 1) begin
      aceso_m = !(s && slot > 0 && (ativo_m >> (4 * slot)) == 16'h0);
    end
    @(negedge clk);
    k++;
  endtask

  // Continuous invariants: one anode at most, decoder input steady while lit
  logic [3:0] an_ant;
  logic [3:0] bcd_ant;
  always @(negedge clk) begin
    if (!rst_n) begin
      an_ant <= 4'hF;
    end else begin
      verifica("um_anodo", 32'($countones(~anodo_n) <= 1), 32'd1);
      if (anodo_n != 4'hF && anodo_n == an_ant)
        verifica("bcd_estavel", 32'(bcd_decod), 32'(bcd_ant));
      an_ant  <= anodo_n;
      bcd_ant <= bcd_decod;
    end
  end

  initial begin
    rst_n       = 1'b0;
    carga_valid = 1'b0;
    dados_bcd   = 16'h0;
    supr_zeros  = 1'b0;
    k           = 0;
    ativo_m     = 16'h0;
    aceso_m     = 1'b1;
    repeat (3) @(negedge clk);
    verifica("reset_anodo", 32'(anodo_n), 32'hF);
    verifica("reset_bcd", 32'(bcd_decod), 32'h0);
    verifica("reset_fim", 32'(fim_quadro), 32'h0);
    verifica("reset_ready", 32'(carga_ready), 32'h1);
    rst_n = 1'b1;

    // Idle frames after reset
    repeat (40) passo(1'b0, 16'h0, 1'b0);

    // Mid-frame load, with extra offers while busy that must be ignored
    passo(1'b1, 16'h1234, 1'b0);
    repeat (4) passo(1'b1, 16'hFFFF, 1'b0);
    repeat (70) passo(1'b0, 16'h0, 1'b0);

    // Leading-zero suppression on, then off
    passo(1'b1, 16'h0070, 1'b1);
    repeat (80) passo(1'b0, 16'h0, 1'b1);
    repeat (40) passo(1'b0, 16'h0, 1'b0);

    // Load offered on the frame-end cycle
    while (k % QUADRO != QUADRO - 1) passo(1'b0, 16'h0, 1'b0);
    passo(1'b1, 16'h5678, 1'b0);
    repeat (70) passo(1'b0, 16'h0, 1'b0);

    // Non-BCD nibbles pass through; then all-zero value with suppression
    passo(1'b1, 16'hABCD, 1'b0);
    repeat (40) passo(1'b0, 16'h0, 1'b0);
    passo(1'b1, 16'h0000, 1'b1);
    repeat (70) passo(1'b0, 16'h0, 1'b1);

    // Reset while a digit is lit and a load is pending
    while (k % QUADRO != 2) passo(1'b0, 16'h0, 1'b0);
    passo(1'b1, 16'h9999, 1'b0);
    repeat (2) passo(1'b0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    verifica("rst_async_anodo", 32'(anodo_n), 32'hF);
    verifica("rst_async_bcd", 32'(bcd_decod), 32'h0);
    verifica("rst_async_ready", 32'(carga_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    ativo_m = 16'h0;
    aceso_m = 1'b1;
    fila.delete();
    repeat (70) passo(1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_controlador_varredura_display
